// File: rtl/img_frame_loader.sv
// -----------------------------------------------------------------------------
// img_frame_loader
// Ingest side of the CNN image path. Accepts a streamed RGB pixel frame over a
// valid/ready handshake, converts every pixel to grayscale floor((R+G+B)/3) and
// stores it row-major in an internal IMG_H x IMG_W frame buffer. Once a full
// frame is stored the loader stops accepting beats until the reader releases
// the buffer with consume.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready     pixel beat handshake
//   s_sof               first pixel of a frame, qualified by s_valid
//   s_r/s_g/s_b         colour channels, PIX_W bits each
//   frame_done          one-cycle pulse after the last pixel is written
//   frame_valid         level, buffer holds a complete frame
//   consume             reader releases the buffer (only honoured when full)
//   rd_addr/rd_data     registered read port, one cycle latency
//   pix_count           pixels written into the current frame
//   drop_cnt            beats discarded while waiting for SOF, saturating
//   resync_err          sticky, SOF seen in the middle of a frame
// -----------------------------------------------------------------------------
module img_frame_loader #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int PIX_W = 8,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_sof,
    input  logic [PIX_W-1:0] s_r,
    input  logic [PIX_W-1:0] s_g,
    input  logic [PIX_W-1:0] s_b,
    output logic             frame_done,
    output logic             frame_valid,
    input  logic             consume,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rd_data,
    output logic [AW:0]      pix_count,
    output logic [7:0]       drop_cnt,
    output logic             resync_err
);

    localparam int unsigned DEPTH   = IMG_W * IMG_H;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_C  = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    // Grayscale conversion: sum is two bits wider than a channel so it cannot
    // overflow; the quotient never exceeds 255 so the truncation is lossless.
    function automatic logic [PIX_W-1:0] gray_of(
        input logic [PIX_W-1:0] r,
        input logic [PIX_W-1:0] g,
        input logic [PIX_W-1:0] b
    );
        logic [PIX_W+1:0] sum;
        sum = {2'b00, r} + {2'b00, g} + {2'b00, b};
        return PIX_W'(sum / (PIX_W+2)'(3));
    endfunction

    state_t            state_q, state_d;
    logic [AW:0]       pix_count_q, pix_count_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic              resync_err_q, resync_err_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_valid_q;
    logic              s_ready_q;
    logic [PIX_W-1:0]  rd_data_q;

    logic              accept_s;
    logic              wr_en_s;
    logic [AW-1:0]     wr_addr_s;
    logic [PIX_W-1:0]  gray_s;
    logic              rd_in_range_s;

    logic [PIX_W-1:0]  mem_q [DEPTH];

    assign accept_s      = s_valid & s_ready_q;
    assign gray_s        = gray_of(s_r, s_g, s_b);
    assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH_C);

    // Next-state, buffer write strobe and counter updates.
    always_comb begin
        state_d      = state_q;
        pix_count_d  = pix_count_q;
        drop_cnt_d   = drop_cnt_q;
        resync_err_d = resync_err_q;
        frame_done_d = 1'b0;
        wr_en_s      = 1'b0;
        wr_addr_s    = {AW{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (accept_s && s_sof) begin
                    wr_en_s     = 1'b1;
                    pix_count_d = ONE_C;
                    state_d     = ST_LOAD;
                end else if (accept_s) begin
                    drop_cnt_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s && s_sof) begin
                    // Abandon the partial frame and restart at address 0.
                    wr_en_s      = 1'b1;
                    pix_count_d  = ONE_C;
                    resync_err_d = 1'b1;
                end else if (accept_s) begin
                    wr_en_s     = 1'b1;
                    wr_addr_s   = pix_count_q[AW-1:0];
                    pix_count_d = pix_count_q + ONE_C;
                    if (pix_count_q == LAST_C) begin
                        state_d      = ST_FULL;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_FULL: begin
                if (consume) begin
                    state_d     = ST_IDLE;
                    pix_count_d = {(AW+1){1'b0}};
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                pix_count_d = {(AW+1){1'b0}};
            end
        endcase
    end

    // Control state and registered status outputs; ready/valid follow the
    // next state so they change in the same cycle as frame_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pix_count_q   <= {(AW+1){1'b0}};
            drop_cnt_q    <= 8'd0;
            resync_err_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            s_ready_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            pix_count_q   <= pix_count_d;
            drop_cnt_q    <= drop_cnt_d;
            resync_err_q  <= resync_err_d;
            frame_done_q  <= frame_done_d;
            frame_valid_q <= (state_d == ST_FULL);
            s_ready_q     <= (state_d != ST_FULL);
        end
    end

    // Frame buffer write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= gray_s;
        end
    end

    // Registered read port; a same-cycle write is seen on the following read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= {PIX_W{1'b0}};
        end else begin
            rd_data_q <= rd_in_range_s ? mem_q[rd_addr] : {PIX_W{1'b0}};
        end
    end

    assign s_ready     = s_ready_q;
    assign frame_done  = frame_done_q;
    assign frame_valid = frame_valid_q;
    assign pix_count   = pix_count_q;
    assign drop_cnt    = drop_cnt_q;
    assign resync_err  = resync_err_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_img_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_img_frame_loader
// Self-checking bench for img_frame_loader. A frame-level reference model
// (expected buffer image, pixel count, drop counter, resync flag) is updated
// for every accepted beat and compared against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_img_frame_loader;

    localparam int NPIX = 1024;

    logic       clk;
    logic       rst_n;
    logic       s_valid;
    logic       s_ready;
    logic       s_sof;
    logic [7:0] s_r, s_g, s_b;
    logic       frame_done;
    logic       frame_valid;
    logic       consume;
    logic [9:0] rd_addr;
    logic [7:0] rd_data;
    logic [10:0] pix_count;
    logic [7:0] drop_cnt;
    logic       resync_err;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;

    // reference model
    int  ref_buf [NPIX];
    int  m_cnt = 0;
    bit  m_loading = 0;
    bit  m_full = 0;
    int  m_drop = 0;
    bit  m_resync = 0;
    bit  m_done = 0;

    img_frame_loader dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
        .s_r(s_r), .s_g(s_g), .s_b(s_b),
        .frame_done(frame_done), .frame_valid(frame_valid),
        .consume(consume), .rd_addr(rd_addr), .rd_data(rd_data),
        .pix_count(pix_count), .drop_cnt(drop_cnt), .resync_err(resync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_seen++;
    end

    function automatic int gray_ref(input int r, input int g, input int b);
        return (r + g + b) / 3;
    endfunction

    // Frame-level reference update for one accepted beat.
    task automatic model_accept(input int r, input int g, input int b, input bit sof);
        m_done = 0;
        if (sof) begin
            if (m_loading) m_resync = 1;
            m_loading = 1;
            ref_buf[0] = gray_ref(r, g, b);
            m_cnt = 1;
        end else if (m_loading) begin
            ref_buf[m_cnt] = gray_ref(r, g, b);
            m_cnt++;
            if (m_cnt == NPIX) begin
                m_loading = 0;
                m_full = 1;
                m_done = 1;
            end
        end else begin
            if (m_drop < 255) m_drop++;
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_loading = 0; m_full = 0; m_drop = 0; m_resync = 0; m_done = 0;
    endtask

    // Present one beat after an optional idle gap, wait (bounded) for it to be
    // accepted, then compare status against the model.
    task automatic send_beat(input int r, input int g, input int b, input bit sof, input int gap);
        bit rdy;
        int tries;
        logic [5:0] got, exp;
        for (int i = 0; i < gap; i++) begin
            s_valid = 1'b0;
            s_sof = 1'($urandom_range(0, 1));
            s_r = 8'($urandom); s_g = 8'($urandom); s_b = 8'($urandom);
            @(posedge clk); #1;
        end
        s_valid = 1'b1; s_sof = sof;
        s_r = 8'(r); s_g = 8'(g); s_b = 8'(b);
        tries = 0;
        rdy = 1'b0;
        while (!rdy && tries < 100) begin
            @(negedge clk); rdy = s_ready;
            @(posedge clk); #1;
            tries++;
        end
        s_valid = 1'b0;
        s_sof = 1'b0;
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL beat_timeout: s_ready stayed %0b, required 1 within 100 cycles", s_ready);
        end else begin
            model_accept(r, g, b, sof);
            checks++;
            if (pix_count !== 11'(m_cnt)) begin
                errors++;
                $display("FAIL pix_count: got %0d, expected %0d", pix_count, m_cnt);
            end
            got = {frame_done, frame_valid, s_ready, resync_err, 2'b00};
            exp = {m_done, m_full, !m_full, m_resync, 2'b00};
            if (got !== exp || drop_cnt !== 8'(m_drop)) begin
                errors++;
                $display("FAIL beat_status: done/valid/ready/resync got %b drop %0d, expected %b drop %0d",
                         got[5:2], drop_cnt, exp[5:2], m_drop);
            end
        end
    endtask

    task automatic do_consume();
        consume = 1'b1;
        @(posedge clk); #1;
        consume = 1'b0;
        if (m_full) begin
            m_full = 0;
            m_cnt = 0;
        end
        checks++;
        if (frame_valid !== m_full || s_ready !== !m_full || pix_count !== 11'(m_cnt)) begin
            errors++;
            $display("FAIL consume: valid %b ready %b cnt %0d, expected valid %b ready %b cnt %0d",
                     frame_valid, s_ready, pix_count, m_full, !m_full, m_cnt);
        end
    endtask

    task automatic read_check(input string tag);
        for (int k = 0; k < NPIX; k++) begin
            rd_addr = 10'(k);
            @(posedge clk); #1;
            checks++;
            if (rd_data !== 8'(ref_buf[k])) begin
                errors++;
                $display("FAIL %s addr %0d: got %0d, expected %0d", tag, k, rd_data, ref_buf[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b1 || frame_done !== 1'b0 || frame_valid !== 1'b0 || resync_err !== 1'b0 ||
            pix_count !== 11'd0 || drop_cnt !== 8'd0 || rd_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: rdy %b done %b valid %b rsy %b cnt %0d drop %0d rd %0d, expected 1 0 0 0 0 0 0",
                     s_ready, frame_done, frame_valid, resync_err, pix_count, drop_cnt, rd_data);
        end
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_full_frame();
        int d0;
        d0 = done_seen;
        for (int i = 0; i < NPIX; i++) send_beat(i % 256, i % 256, i % 256, i == 0, 0);
        // pulse is one cycle only
        @(posedge clk); #1;
        checks++;
        if (frame_done !== 1'b0 || frame_valid !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_width: done %b valid %b ready %b, expected 0 1 0",
                     frame_done, frame_valid, s_ready);
        end
        read_check("ramp_frame");
        checks++;
        if (done_seen - d0 !== 1) begin
            errors++;
            $display("FAIL ramp_done_count: got %0d pulses, expected 1", done_seen - d0);
        end
        do_consume();
    endtask

    task automatic test_drop();
        int r0, g0, b0;
        for (int i = 0; i < 5; i++) send_beat($urandom_range(0, 255), 7, 9, 1'b0, 0);
        checks++;
        if (drop_cnt !== 8'd5) begin
            errors++;
            $display("FAIL drop_five: got %0d, expected 5", drop_cnt);
        end
        r0 = $urandom_range(0, 255); g0 = $urandom_range(0, 255); b0 = $urandom_range(0, 255);
        send_beat(r0, g0, b0, 1'b1, 0);
        for (int i = 1; i < NPIX; i++)
            send_beat($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 0);
        rd_addr = 10'd0;
        @(posedge clk); #1;
        checks++;
        if (rd_data !== 8'(gray_ref(r0, g0, b0))) begin
            errors++;
            $display("FAIL drop_first_sof: got %0d, expected %0d", rd_data, gray_ref(r0, g0, b0));
        end
        read_check("drop_frame");
        do_consume();
        for (int i = 0; i < 300; i++) send_beat(1, 2, 3, 1'b0, 0);
        checks++;
        if (drop_cnt !== 8'd255) begin
            errors++;
            $display("FAIL drop_saturate: got %0d, expected 255", drop_cnt);
        end
    endtask

    task automatic test_resync();
        int r0, g0, b0, d0;
        d0 = done_seen;
        for (int i = 0; i < 500; i++)
            send_beat($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), i == 0, 0);
        r0 = $urandom_range(0, 255); g0 = $urandom_range(0, 255); b0 = $urandom_range(0, 255);
        send_beat(r0, g0, b0, 1'b1, 0);
        for (int i = 0; i < NPIX - 1; i++)
            send_beat($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 0);
        rd_addr = 10'd0;
        @(posedge clk); #1;
        checks++;
        if (resync_err !== 1'b1 || frame_valid !== 1'b1 || rd_data !== 8'(gray_ref(r0, g0, b0))) begin
            errors++;
            $display("FAIL resync: rsy %b valid %b addr0 %0d, expected 1 1 %0d",
                     resync_err, frame_valid, rd_data, gray_ref(r0, g0, b0));
        end
        checks++;
        if (done_seen - d0 !== 1) begin
            errors++;
            $display("FAIL resync_done_count: got %0d, expected 1", done_seen - d0);
        end
        read_check("resync_frame");
    endtask

    // Buffer is full here: consume with a pending SOF beat in the same cycle.
    task automatic test_consume_sof();
        s_valid = 1'b1; s_sof = 1'b1; s_r = 8'd30; s_g = 8'd60; s_b = 8'd90;
        consume = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL consume_sof_blocked: ready %b, expected 0", s_ready);
        end
        @(posedge clk); #1;
        consume = 1'b0;
        m_full = 0; m_cnt = 0;
        checks++;
        if (frame_valid !== 1'b0 || s_ready !== 1'b1 || pix_count !== 11'd0) begin
            errors++;
            $display("FAIL consume_sof_idle: valid %b ready %b cnt %0d, expected 0 1 0",
                     frame_valid, s_ready, pix_count);
        end
        send_beat(30, 60, 90, 1'b1, 0);
        rd_addr = 10'd0;
        @(posedge clk); #1;
        checks++;
        if (rd_data !== 8'd60) begin
            errors++;
            $display("FAIL consume_sof_new: got %0d, expected 60", rd_data);
        end
    endtask

    // Continues the frame started above: corners first, random data and gaps.
    task automatic test_gaps_corners();
        int cr [5] = '{255, 1, 2, 255, 0};
        int cg [5] = '{255, 1, 2, 255, 0};
        int cb [5] = '{255, 0, 2, 254, 3};
        int ce [5] = '{255, 0, 2, 254, 1};
        int d0, gap;
        d0 = done_seen;
        for (int i = 1; i < NPIX; i++) begin
            gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            if (i <= 5) send_beat(cr[i-1], cg[i-1], cb[i-1], 1'b0, gap);
            else send_beat($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, gap);
        end
        for (int i = 0; i < 5; i++) begin
            rd_addr = 10'(i + 1);
            @(posedge clk); #1;
            checks++;
            if (rd_data !== 8'(ce[i])) begin
                errors++;
                $display("FAIL gray_corner_%0d: got %0d, expected %0d", i, rd_data, ce[i]);
            end
        end
        read_check("gap_frame");
        checks++;
        if (done_seen - d0 !== 1) begin
            errors++;
            $display("FAIL gap_done_count: got %0d, expected 1", done_seen - d0);
        end
        do_consume();
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 700; i++)
            send_beat($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), i == 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b1 || frame_done !== 1'b0 || frame_valid !== 1'b0 || resync_err !== 1'b0 ||
            pix_count !== 11'd0 || drop_cnt !== 8'd0 || rd_data !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: rdy %b done %b valid %b rsy %b cnt %0d drop %0d rd %0d, expected 1 0 0 0 0 0 0",
                     s_ready, frame_done, frame_valid, resync_err, pix_count, drop_cnt, rd_data);
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NPIX; i++)
            send_beat($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), i == 0, 0);
        read_check("post_reset_frame");
    endtask

    initial begin
        s_valid = 1'b0; s_sof = 1'b0; s_r = 8'd0; s_g = 8'd0; s_b = 8'd0;
        consume = 1'b0; rd_addr = 10'd0; rst_n = 1'b0;
        test_reset();
        test_full_frame();
        test_drop();
        test_resync();
        test_consume_sof();
        test_gaps_corners();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
